// File: rtl/spi_slave_sync_pkg.sv
// Shared widths, opcodes and FSM states for the SPI register-access slave.
//   DWIDTH / AWIDTH : default data / address field widths
//   spi_op_e        : decoded opcodes (anything else is a no-op)
//   spi_state_e     : frame FSM states
//   frame_bits()    : total serial bits in one frame
package spi_pkg;

  localparam int unsigned DWIDTH  = 8;
  localparam int unsigned AWIDTH  = 5;
  localparam int unsigned OP_BITS = 3;

  typedef enum logic [OP_BITS-1:0] {
    OP_WR = 3'b001,
    OP_RD = 3'b010
  } spi_op_e;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    WAIT_SS
  } spi_state_e;

  function automatic int unsigned frame_bits(input int unsigned aw, input int unsigned dw);
    return OP_BITS + aw + dw;
  endfunction

  localparam int unsigned FRAME_BITS = frame_bits(AWIDTH, DWIDTH);

endpackage

// File: rtl/spi_slave_sync_if.sv
// Register-file side bus of the SPI slave.
//   master : driven by the SPI slave (strobes, address, write data), reads reg_rdata
//   slave  : the register file, returns reg_rdata one clk after reg_rd
interface spi_slave_sync_if
  import spi_pkg::*;
#(
  parameter int unsigned AWIDTH = spi_pkg::AWIDTH,
  parameter int unsigned DWIDTH = spi_pkg::DWIDTH
);

  logic              reg_wr;
  logic              reg_rd;
  logic [AWIDTH-1:0] reg_addr;
  logic [DWIDTH-1:0] reg_wdata;
  logic [DWIDTH-1:0] reg_rdata;

  modport master (
    output reg_wr, reg_rd, reg_addr, reg_wdata,
    input  reg_rdata
  );

  modport slave (
    input  reg_wr, reg_rd, reg_addr, reg_wdata,
    output reg_rdata
  );

endinterface

// File: rtl/spi_slave_sync_sync_edge.sv
// Multi-flop synchroniser followed by a registered previous-value stage for
// rise/fall detection of an asynchronous pin.
//   clk, rst : system clock, async active-high reset
//   din      : asynchronous input pin
//   rise_c   : one-cycle pulse when the synchronised level goes 0->1
//   fall_c   : one-cycle pulse when the synchronised level goes 1->0
// The pulses are decoded from flop outputs only (no path from din).
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchroniser chain plus edge-detect register, all resetting to the pin's idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  always_comb begin
    rise_c = ~prev_q &  sync_q[STAGES-1];
    fall_c =  prev_q & ~sync_q[STAGES-1];
  end

endmodule

// File: rtl/spi_slave_sync.sv
// Oversampling SPI slave for register access, clocked by the system clock.
// Frame (MSB first): {op[2:0], addr[AWIDTH-1:0], data[DWIDTH-1:0]}.
//   clk, rst       : system clock, async active-high reset
//   mode           : {cpol, cpha}, latched when ss_n falls
//   sck, mosi, ss_n: asynchronous SPI pins
//   miso           : serial read data (0 outside the data phase)
//   frame_done/err : one-cycle pulse at ss_n rising for a correct/wrong length frame
//   bus            : register strobes, address, write data and returned read data
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int unsigned DWIDTH      = spi_pkg::DWIDTH,
  parameter int unsigned AWIDTH      = spi_pkg::AWIDTH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic               sck,
  input  logic               mosi,
  input  logic               ss_n,
  output logic               miso,
  output logic               frame_done,
  output logic               frame_err,
  spi_slave_sync_if.master   bus
);

  localparam int unsigned FB  = frame_bits(AWIDTH, DWIDTH);
  localparam int unsigned HB  = OP_BITS + AWIDTH;
  localparam int unsigned CW  = $clog2(FB + 2);
  localparam int unsigned BW  = $clog2(SYNC_STAGES + 2);
  // Receive shifter only needs to hold the header minus its last bit, or the data field.
  localparam int unsigned RXW = ((HB - 1) > DWIDTH) ? (HB - 1) : DWIDTH;

  logic sck_rise_c, sck_fall_c, ss_rise_c, ss_fall_c;
  logic [SYNC_STAGES-1:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (sck),
    .rise_c (sck_rise_c),
    .fall_c (sck_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (ss_n),
    .rise_c (ss_rise_c),
    .fall_c (ss_fall_c)
  );

  // mosi only needs a level, aligned with the sck edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_q <= '0;
    else     mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_q[SYNC_STAGES-1];

  spi_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [RXW-1:0]    rx_q, rx_d;
  logic [2:0]        op_q, op_d;
  logic [DWIDTH-1:0] tx_q, tx_d;
  logic              rd_go_q, rd_go_d;
  logic              wr_go_q, wr_go_d;
  logic              ld_q, ld_d;
  logic [BW-1:0]     boot_q, boot_d;
  logic              miso_d, done_d, err_d, wr_d, rd_d;
  logic [AWIDTH-1:0] addr_d;
  logic [DWIDTH-1:0] wdata_d;
  logic              samp_c, shft_c;
  logic [HB-1:0]     hdr_c;
  logic [CW-1:0]     cnt_nx_c;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mode_q        <= '0;
      rx_q          <= '0;
      op_q          <= '0;
      tx_q          <= '0;
      rd_go_q       <= 1'b0;
      wr_go_q       <= 1'b0;
      ld_q          <= 1'b0;
      boot_q        <= BW'(SYNC_STAGES + 1);
      miso          <= 1'b0;
      frame_done    <= 1'b0;
      frame_err     <= 1'b0;
      bus.reg_wr    <= 1'b0;
      bus.reg_rd    <= 1'b0;
      bus.reg_addr  <= '0;
      bus.reg_wdata <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mode_q        <= mode_d;
      rx_q          <= rx_d;
      op_q          <= op_d;
      tx_q          <= tx_d;
      rd_go_q       <= rd_go_d;
      wr_go_q       <= wr_go_d;
      ld_q          <= ld_d;
      boot_q        <= boot_d;
      miso          <= miso_d;
      frame_done    <= done_d;
      frame_err     <= err_d;
      bus.reg_wr    <= wr_d;
      bus.reg_rd    <= rd_d;
      bus.reg_addr  <= addr_d;
      bus.reg_wdata <= wdata_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    rx_d    = rx_q;
    op_d    = op_q;
    tx_d    = tx_q;
    rd_go_d = 1'b0;
    wr_go_d = 1'b0;
    ld_d    = bus.reg_rd;
    boot_d  = (boot_q != '0) ? boot_q - BW'(1) : boot_q;
    miso_d  = miso;
    done_d  = 1'b0;
    err_d   = 1'b0;
    rd_d    = rd_go_q;
    wr_d    = wr_go_q;
    addr_d  = bus.reg_addr;
    wdata_d = wr_go_q ? rx_q[DWIDTH-1:0] : bus.reg_wdata;

    // Sample edge is rising when cpol==cpha; shift edge is the other one.
    samp_c   = (mode_q[1] == mode_q[0]) ? sck_rise_c : sck_fall_c;
    shft_c   = (mode_q[1] == mode_q[0]) ? sck_fall_c : sck_rise_c;
    hdr_c    = {rx_q[HB-2:0], mosi_s};
    cnt_nx_c = cnt_q + CW'(1);

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (ss_fall_c) begin
          cnt_d = '0;
          tx_d  = '0;
          // A select seen right after reset is a partial frame: park until it ends.
          if (boot_q != '0) begin
            state_d = WAIT_SS;
          end else begin
            mode_d  = mode;
            state_d = HDR;
          end
        end
      end
      HDR: begin
        if (samp_c) begin
          rx_d  = {rx_q[RXW-2:0], mosi_s};
          cnt_d = cnt_nx_c;
          if (cnt_nx_c == CW'(HB)) begin
            op_d    = hdr_c[HB-1:AWIDTH];
            addr_d  = hdr_c[AWIDTH-1:0];
            rd_go_d = (hdr_c[HB-1:AWIDTH] == OP_RD);
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (shft_c) begin
          miso_d = tx_q[DWIDTH-1];
          tx_d   = {tx_q[DWIDTH-2:0], 1'b0};
        end
        if (samp_c) begin
          rx_d  = {rx_q[RXW-2:0], mosi_s};
          cnt_d = cnt_nx_c;
          if (cnt_nx_c == CW'(FB)) begin
            wr_go_d = (op_q == OP_WR);
            state_d = WAIT_SS;
          end
        end
      end
      WAIT_SS: begin
        if (samp_c && (cnt_q != CW'(FB + 1))) cnt_d = cnt_nx_c;
      end
      default: state_d = IDLE;
    endcase

    // Read data lands two clk after the address decode, well before the first shift edge.
    if (ld_q) tx_d = bus.reg_rdata;

    // Deselect ends the frame from any active state.
    if ((state_q != IDLE) && ss_rise_c) begin
      state_d = IDLE;
      miso_d  = 1'b0;
      done_d  = (cnt_q == CW'(FB));
      err_d   = (cnt_q != CW'(FB));
    end
  end

endmodule

// File: tb/tb_spi_slave_sync.sv
// Directed bench for spi_slave_sync: DWIDTH=8, AWIDTH=5, clk = 16 x sck.
module tb_spi_slave_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] mode = 2'd0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       ss_n = 1'b1;
  logic       miso, frame_done, frame_err;
  logic [7:0] rd_val = 8'h00;

  int n_chk = 0;
  int n_bad = 0;
  int n_wr, n_rd, n_done, n_err;
  logic [4:0]  wr_addr, rd_addr;
  logic [7:0]  wr_data;
  logic [31:0] rxw;

  always #5 clk = ~clk;

  spi_slave_sync_if #(.AWIDTH(5), .DWIDTH(8)) bus ();

  spi_slave_sync #(.DWIDTH(8), .AWIDTH(5), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .mode       (mode),
    .sck        (sck),
    .mosi       (mosi),
    .ss_n       (ss_n),
    .miso       (miso),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .bus        (bus)
  );

  // Register file: data valid only in the cycle after reg_rd, garbage otherwise.
  always @(posedge clk) bus.reg_rdata <= bus.reg_rd ? rd_val : ~rd_val;

  // Strobe monitor.
  always @(negedge clk) begin
    if (bus.reg_wr) begin
      n_wr++;
      wr_addr = bus.reg_addr;
      wr_data = bus.reg_wdata;
    end
    if (bus.reg_rd) begin
      n_rd++;
      rd_addr = bus.reg_addr;
    end
    if (frame_done) n_done++;
    if (frame_err)  n_err++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_rd = 0; n_done = 0; n_err = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // SPI master: sends nbits of vec MSB first, samples miso on each sample edge.
  // flip_at: bit at which the mode pin is disturbed; rst_at: bit during which rst pulses.
  task automatic xfer(input logic [1:0] m, input int nbits, input logic [31:0] vec,
                      input int flip_at, input int rst_at, output logic [31:0] rx);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[0];
    mode = m;
    sck  = cpol;
    rx   = '0;
    wait_clk(8);
    ss_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == flip_at) mode = ~m;
      if (cpha == 1'b0) mosi = vec[nbits-1-i];
      else begin
        sck  = ~cpol;
        mosi = vec[nbits-1-i];
      end
      wait_clk(8);
      sck = (cpha == 1'b0) ? ~cpol : cpol;
      rx  = {rx[30:0], miso};
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_miso", miso, 0);
        chk("rstmid_strobes", {bus.reg_wr, bus.reg_rd, frame_done, frame_err}, 0);
        chk("rstmid_addr", bus.reg_addr, 0);
        chk("rstmid_wdata", bus.reg_wdata, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_clk(2);
      end else begin
        wait_clk(4);
      end
      wait_clk(4);
      if (cpha == 1'b0) sck = cpol;
    end
    wait_clk(8);
    ss_n = 1'b1;
    mode = m;
    wait_clk(16);
  endtask

  initial begin
    clr();
    wait_clk(4);
    chk("rst_miso", miso, 0);
    chk("rst_strobes", {bus.reg_wr, bus.reg_rd, frame_done, frame_err}, 0);
    chk("rst_addr", bus.reg_addr, 0);
    chk("rst_wdata", bus.reg_wdata, 0);
    rst = 1'b0;
    wait_clk(10);

    // Mode 0 write: {001, 0A, A5}
    clr();
    xfer(2'd0, 16, 32'h2AA5, -1, -1, rxw);
    chk("w0_nwr", n_wr, 1);
    chk("w0_addr", wr_addr, 5'h0A);
    chk("w0_data", wr_data, 8'hA5);
    chk("w0_nrd", n_rd, 0);
    chk("w0_done", n_done, 1);
    chk("w0_err", n_err, 0);
    chk("w0_miso", rxw, 0);

    // Mode 3 read: {010, 11, 00} returning 3C
    clr();
    rd_val = 8'h3C;
    xfer(2'd3, 16, 32'h5100, -1, -1, rxw);
    chk("r3_nrd", n_rd, 1);
    chk("r3_addr", rd_addr, 5'h11);
    chk("r3_miso", rxw, 32'h003C);
    chk("r3_nwr", n_wr, 0);
    chk("r3_done", n_done, 1);

    // All modes, read of 96 from addr 03, mode pin disturbed mid-frame
    for (int m = 0; m < 4; m++) begin
      clr();
      rd_val = 8'h96;
      xfer(2'(m), 16, 32'h4300, 4, -1, rxw);
      chk($sformatf("rm%0d_miso", m), rxw, 32'h0096);
      chk($sformatf("rm%0d_addr", m), rd_addr, 5'h03);
      chk($sformatf("rm%0d_cnt", m), {n_rd[7:0], n_done[7:0], n_err[7:0]}, 32'h010100);
    end

    // Mode 1 read ending in a 1: miso must return to 0 once deselected
    clr();
    rd_val = 8'h81;
    xfer(2'd1, 16, 32'h4300, -1, -1, rxw);
    chk("r1_miso", rxw, 32'h0081);
    chk("r1_idle_miso", miso, 0);

    // Write aborted after 10 bits
    clr();
    xfer(2'd0, 10, 32'h00AA, -1, -1, rxw);
    chk("ab_nwr", n_wr, 0);
    chk("ab_err", n_err, 1);
    chk("ab_done", n_done, 0);

    // 18-bit frame: first 16 bits are {001, 07, 5A}
    clr();
    xfer(2'd0, 18, 32'h9D6B, -1, -1, rxw);
    chk("lg_nwr", n_wr, 1);
    chk("lg_addr", wr_addr, 5'h07);
    chk("lg_data", wr_data, 8'h5A);
    chk("lg_err", n_err, 1);
    chk("lg_done", n_done, 0);

    // op=111 no-op frame
    clr();
    xfer(2'd0, 16, 32'hE5FF, -1, -1, rxw);
    chk("nop_strobes", n_wr + n_rd, 0);
    chk("nop_done", n_done, 1);
    chk("nop_err", n_err, 0);

    // Reset during bit 6 with ss_n held low, then a normal frame
    clr();
    xfer(2'd0, 16, 32'h2AA5, -1, 5, rxw);
    chk("rf_strobes", n_wr + n_rd, 0);
    chk("rf_done", n_done, 0);
    chk("rf_err", n_err, 1);
    clr();
    xfer(2'd0, 16, 32'h2AA5, -1, -1, rxw);
    chk("ok_nwr", n_wr, 1);
    chk("ok_data", wr_data, 8'hA5);
    chk("ok_done", n_done, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
